// File: rtl/store_unload_pkg.sv
// Shared definitions for the load/store volume controller pair: default volume
// and counter width, plus the drain-side state encoding.
package load_store_pkg;

    localparam int N_DEFAULT     = 100000;
    localparam int CBITS_DEFAULT = 17;

    typedef enum logic [1:0] {
        WAIT_FULL = 2'd0,
        DRAIN     = 2'd1,
        EMPTY     = 2'd2
    } unload_state_t;

endpackage

// File: rtl/store_unload_rise_detect.sv
// Rising-edge detector for a level input: one history register and an AND.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic level_i,
    output logic rise_o
);

    logic level_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_i;
        end
    end

    assign rise_o = level_i & ~level_q;

endmodule

// File: rtl/store_unload.sv
// Drain side of the load/store volume controller: on a producer "full" edge it
// captures N units and hands them downstream STEP units per accepted beat.
module store_unload
    import load_store_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int CBITS = CBITS_DEFAULT,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             full_in,
    input  logic             take_ready,
    output logic             take_valid,
    output logic [CBITS-1:0] take_units,
    output logic [CBITS-1:0] vol,
    output logic             sig,
    output logic             overrun
);

    localparam logic [CBITS-1:0] N_C    = CBITS'(N);
    localparam logic [CBITS-1:0] STEP_C = CBITS'(STEP);

    unload_state_t    state_q;
    logic [CBITS-1:0] vol_q;
    logic [CBITS-1:0] units_q;
    logic             valid_q;
    logic             sig_q;
    logic             overrun_q;

    logic             rise;
    logic             fire;
    logic [CBITS-1:0] vol_d;

    function automatic logic [CBITS-1:0] beat_size(input logic [CBITS-1:0] v);
        return (v < STEP_C) ? v : STEP_C;
    endfunction

    rise_detect u_full_rise (
        .clk     (clk),
        .rst     (rst),
        .level_i (full_in),
        .rise_o  (rise)
    );

    assign fire  = valid_q & take_ready;
    // units_q never exceeds vol_q while a beat is offered, so this cannot wrap.
    assign vol_d = vol_q - units_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= WAIT_FULL;
            vol_q     <= '0;
            units_q   <= '0;
            valid_q   <= 1'b0;
            sig_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (rise && (state_q != WAIT_FULL)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                WAIT_FULL: begin
                    if (rise) begin
                        vol_q   <= N_C;
                        units_q <= beat_size(N_C);
                        valid_q <= 1'b1;
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (fire) begin
                        vol_q <= vol_d;
                        if (vol_d == '0) begin
                            units_q <= '0;
                            valid_q <= 1'b0;
                            sig_q   <= 1'b1;
                            state_q <= EMPTY;
                        end else begin
                            units_q <= beat_size(vol_d);
                        end
                    end
                end
                EMPTY: begin
                    // Re-arm only once the producer has dropped its full level.
                    if (!full_in) begin
                        sig_q   <= 1'b0;
                        state_q <= WAIT_FULL;
                    end
                end
                default: begin
                    state_q <= WAIT_FULL;
                    valid_q <= 1'b0;
                    sig_q   <= 1'b0;
                end
            endcase
        end
    end

    assign take_valid = valid_q;
    assign take_units = units_q;
    assign vol        = vol_q;
    assign sig        = sig_q;
    assign overrun    = overrun_q;

    a_vol_bounded : assert property (@(posedge clk) disable iff (rst) vol_q <= N_C);
    a_no_empty_beat : assert property (@(posedge clk) disable iff (rst)
        valid_q |-> (vol_q != '0) && (units_q != '0) && (units_q <= vol_q));

endmodule

// File: tb/tb_store_unload.sv
// Scoreboard bench for store_unload: three instances (N=8/STEP=3, N=4/STEP=1,
// N=1000/STEP=100) with per-instance expected-beat queues checked by monitors.
module tb_store_unload;

    typedef struct {
        int units;
        int vol;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        full_a = 0, ready_a = 0, valid_a, sig_a, ovr_a;
    logic [16:0] units_a, vol_a;
    logic        full_b = 0, ready_b = 0, valid_b, sig_b, ovr_b;
    logic [16:0] units_b, vol_b;
    logic        full_c = 0, ready_c = 0, valid_c, sig_c, ovr_c;
    logic [16:0] units_c, vol_c;

    beat_t q_a[$];
    beat_t q_b[$];
    beat_t q_c[$];

    int tests = 0;
    int fails = 0;

    store_unload #(.N(8), .CBITS(17), .STEP(3)) dut_a (
        .clk(clk), .rst(rst), .full_in(full_a), .take_ready(ready_a),
        .take_valid(valid_a), .take_units(units_a), .vol(vol_a),
        .sig(sig_a), .overrun(ovr_a)
    );
    store_unload #(.N(4), .CBITS(17), .STEP(1)) dut_b (
        .clk(clk), .rst(rst), .full_in(full_b), .take_ready(ready_b),
        .take_valid(valid_b), .take_units(units_b), .vol(vol_b),
        .sig(sig_b), .overrun(ovr_b)
    );
    store_unload #(.N(1000), .CBITS(17), .STEP(100)) dut_c (
        .clk(clk), .rst(rst), .full_in(full_c), .take_ready(ready_c),
        .take_valid(valid_c), .take_units(units_c), .vol(vol_c),
        .sig(sig_c), .overrun(ovr_c)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int which, input int units, input int v);
        beat_t b;
        b.units = units;
        b.vol   = v;
        case (which)
            0: q_a.push_back(b);
            1: q_b.push_back(b);
            default: q_c.push_back(b);
        endcase
    endtask

    // Monitors: every offered beat is compared against the queue head; the
    // head is consumed only on an accepted beat, so stalls recheck the same beat.
    always @(negedge clk) begin
        if (!rst && valid_a) begin
            if (q_a.size() == 0) begin
                tests++; fails++;
                $display("FAIL a_extra_beat: units %0d vol %0d offered, none expected", units_a, vol_a);
            end else begin
                chk("a_units", units_a, q_a[0].units);
                chk("a_vol", vol_a, q_a[0].vol);
                if (ready_a) void'(q_a.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && valid_b) begin
            if (q_b.size() == 0) begin
                tests++; fails++;
                $display("FAIL b_extra_beat: units %0d vol %0d offered, none expected", units_b, vol_b);
            end else begin
                chk("b_units", units_b, q_b[0].units);
                chk("b_vol", vol_b, q_b[0].vol);
                if (ready_b) void'(q_b.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && valid_c) begin
            if (q_c.size() == 0) begin
                tests++; fails++;
                $display("FAIL c_extra_beat: units %0d vol %0d offered, none expected", units_c, vol_c);
            end else begin
                chk("c_units", units_c, q_c[0].units);
                chk("c_vol", vol_c, q_c[0].vol);
                if (ready_c) void'(q_c.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        chk("rst_a_valid", valid_a, 0);
        chk("rst_a_vol", vol_a, 0);
        chk("rst_a_sig", sig_a, 0);
        chk("rst_a_ovr", ovr_a, 0);
        tick(2);

        // T2: N=8, STEP=3, always ready -> beats 3,3,2
        $display("[TB] T2 N=8 STEP=3 drain");
        push(0, 3, 8); push(0, 3, 5); push(0, 2, 2);
        ready_a = 1'b1;
        full_a  = 1'b1;
        tick();
        full_a = 1'b0;
        chk("t2_valid_latency", valid_a, 1);
        chk("t2_first_vol", vol_a, 8);
        tick(2);
        chk("t2_sig_before_last", sig_a, 0);
        tick();
        chk("t2_sig_after_last", sig_a, 1);
        chk("t2_valid_after_last", valid_a, 0);
        chk("t2_vol_empty", vol_a, 0);
        tick();
        chk("t2_rearm_sig", sig_a, 0);
        chk("t2_queue_drained", q_a.size(), 0);
        tick(2);

        // T3: N=4, STEP=1, ready pattern 1,0,0 repeating
        $display("[TB] T3 N=4 STEP=1 stalled drain");
        for (int k = 4; k >= 1; k--) push(1, 1, k);
        full_b = 1'b1;
        tick();
        full_b = 1'b0;
        begin
            int n;
            n = 0;
            while (!sig_b && n < 40) begin
                ready_b = (n % 3 == 0);
                tick();
                n++;
            end
            chk("t3_drain_done", sig_b, 1);
            chk("t3_cycles", n, 10);
        end
        ready_b = 1'b0;
        chk("t3_queue_drained", q_b.size(), 0);
        tick(2);

        // T4: full held after drain keeps EMPTY; drop re-arms; fresh drain
        $display("[TB] T4 full held across EMPTY");
        for (int k = 4; k >= 1; k--) push(1, 1, k);
        ready_b = 1'b1;
        full_b  = 1'b1;
        tick();
        tick(4);
        chk("t4_sig_empty", sig_b, 1);
        tick(3);
        chk("t4_sig_held", sig_b, 1);
        chk("t4_valid_held", valid_b, 0);
        full_b = 1'b0;
        tick();
        chk("t4_rearm_sig", sig_b, 0);
        for (int k = 4; k >= 1; k--) push(1, 1, k);
        full_b = 1'b1;
        tick();
        full_b = 1'b0;
        chk("t4_fresh_valid", valid_b, 1);
        chk("t4_fresh_vol", vol_b, 4);
        tick(4);
        chk("t4_fresh_sig", sig_b, 1);
        chk("t4_no_overrun", ovr_b, 0);
        chk("t4_queue_drained", q_b.size(), 0);
        tick(2);

        // T5: second rise during DRAIN sets sticky overrun only
        $display("[TB] T5 overrun during drain");
        push(0, 3, 8); push(0, 3, 5); push(0, 2, 2);
        ready_a = 1'b0;
        full_a  = 1'b1;
        tick();
        full_a = 1'b0;
        tick();
        full_a = 1'b1;
        tick();
        full_a = 1'b0;
        chk("t5_overrun_set", ovr_a, 1);
        chk("t5_vol_unaffected", vol_a, 8);
        ready_a = 1'b1;
        tick(3);
        chk("t5_sig", sig_a, 1);
        tick(3);
        chk("t5_overrun_sticky", ovr_a, 1);
        chk("t5_queue_drained", q_a.size(), 0);

        // T1: reset mid-drain at vol=500
        $display("[TB] T1 reset mid-drain");
        for (int k = 0; k < 10; k++) push(2, 100, 1000 - 100 * k);
        ready_c = 1'b1;
        full_c  = 1'b1;
        tick();
        full_c = 1'b0;
        tick(5);
        ready_c = 1'b0;
        chk("t1_mid_vol", vol_c, 500);
        rst = 1'b1;
        q_c.delete();
        tick(2);
        rst = 1'b0;
        tick();
        chk("t1_vol", vol_c, 0);
        chk("t1_valid", valid_c, 0);
        chk("t1_sig", sig_c, 0);
        chk("t1_ovr", ovr_c, 0);
        chk("t1_ovr_a_cleared", ovr_a, 0);
        // WAIT_FULL: a new rise must start a full drain again
        for (int k = 0; k < 10; k++) push(2, 100, 1000 - 100 * k);
        ready_c = 1'b1;
        full_c  = 1'b1;
        tick();
        full_c = 1'b0;
        chk("t1_restart_vol", vol_c, 1000);
        tick(10);
        chk("t1_restart_sig", sig_c, 1);
        chk("t1_queue_drained", q_c.size(), 0);
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
